preg_freelist_ctrl: RTL

Allocation controller for the integer physical-register free list feeding the rename stage of the Scheduler.
- Hands out free physical registers to up to ALLOC_PORTS renaming instructions per cycle, all-or-nothing.
- Accepts released physical registers (old mappings) from ROB commit.
- Keeps a speculative head and a committed head so that a pipeline flush restores the free list in one cycle.

---
 rtl/preg_freelist_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/preg_freelist_ctrl.sv
// -----------------------------------------------------------------------------
// preg_freelist_ctrl
//
// Allocation controller for the integer physical-register free list that feeds
// the rename stage. The list is a circular buffer of DEPTH preg numbers with
// three pointers:
//   spec_head - next entry handed to rename (advances on allocation)
//   arch_head - oldest entry not yet consumed by a committed instruction
//               (advances on commit); a flush snaps spec_head back to it
//   tail      - next slot written by a release from commit (advances on free)
// Pointers carry one extra wrap bit above the RAM index, so full and empty
// are distinguishable and all pointer arithmetic is modulo 2*DEPTH.
//
// Ports:
//   clk             clock
//   a_rst_n         asynchronous reset, active low
//   flush_i         misprediction/exception flush; restores spec_head
//   alloc_valid_i   per-lane allocation request (may be sparse)
//   alloc_ready_o   every requesting lane can be served this cycle
//   alloc_preg_o    preg granted per lane (PREG_W bits per lane, lane 0 LSBs)
//   commit_valid_i  per-lane: a committed instruction consumed an entry
//   free_valid_i    per-lane release of an old mapping
//   free_preg_i     preg released per lane (PREG_W bits per lane, lane 0 LSBs)
//   free_count_o    registered number of entries available for allocation
// -----------------------------------------------------------------------------
module preg_freelist_ctrl #(
  parameter  int PHYS_REG_NUM = 64,
  parameter  int ARCH_REG_NUM = 32,
  parameter  int ALLOC_PORTS  = 2,
  parameter  int FREE_PORTS   = 2,
  localparam int PREG_W       = $clog2(PHYS_REG_NUM),
  localparam int DEPTH        = PHYS_REG_NUM - ARCH_REG_NUM,
  localparam int IDX_W        = $clog2(DEPTH),
  localparam int PTR_W        = IDX_W + 1
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  input  logic                          flush_i,
  input  logic [ALLOC_PORTS-1:0]        alloc_valid_i,
  output logic                          alloc_ready_o,
  output logic [ALLOC_PORTS*PREG_W-1:0] alloc_preg_o,
  input  logic [ALLOC_PORTS-1:0]        commit_valid_i,
  input  logic [FREE_PORTS-1:0]         free_valid_i,
  input  logic [FREE_PORTS*PREG_W-1:0]  free_preg_i,
  output logic [PTR_W-1:0]              free_count_o
);

  // Linear-position width: enough for values up to 4*DEPTH-1 so the
  // modular distance below never overflows.
  localparam int                LIN_W       = PTR_W + 1;
  localparam logic [PTR_W-1:0]  DEPTH_P     = PTR_W'(DEPTH);
  localparam logic [LIN_W-1:0]  DEPTH_L     = LIN_W'(DEPTH);
  localparam logic [LIN_W-1:0]  TWO_DEPTH_L = LIN_W'(2 * DEPTH);

  // Advance a wrap-bit pointer by inc (inc <= DEPTH). Works for any DEPTH,
  // not only powers of two: the index folds at DEPTH and flips the wrap bit.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [PTR_W-1:0] inc);
    logic [PTR_W-1:0] sum;
    logic             wrap;
    sum  = {1'b0, ptr[IDX_W-1:0]} + inc;
    wrap = ptr[PTR_W-1];
    if (sum >= DEPTH_P) begin
      sum  = sum - DEPTH_P;
      wrap = ~wrap;
    end
    return {wrap, sum[IDX_W-1:0]};
  endfunction

  // Distance from from_ptr forward to to_ptr, modulo 2*DEPTH.
  function automatic logic [PTR_W-1:0] ptr_dist(input logic [PTR_W-1:0] from_ptr,
                                                input logic [PTR_W-1:0] to_ptr);
    logic [LIN_W-1:0] f;
    logic [LIN_W-1:0] t;
    logic [LIN_W-1:0] d;
    f = (from_ptr[PTR_W-1] ? DEPTH_L : '0) + LIN_W'(from_ptr[IDX_W-1:0]);
    t = (to_ptr[PTR_W-1]   ? DEPTH_L : '0) + LIN_W'(to_ptr[IDX_W-1:0]);
    d = (t >= f) ? (t - f) : (t + TWO_DEPTH_L - f);
    return d[PTR_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PREG_W-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]  spec_head_q;
  logic [PTR_W-1:0]  arch_head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  count_q;

  logic [PTR_W-1:0]  spec_head_d;
  logic [PTR_W-1:0]  arch_head_d;
  logic [PTR_W-1:0]  tail_d;
  logic [PTR_W-1:0]  count_d;

  logic [PTR_W-1:0]  alloc_n;
  logic [PTR_W-1:0]  commit_n;
  logic [PTR_W-1:0]  free_n;
  logic [IDX_W-1:0]  wr_idx [FREE_PORTS];
  logic              fire;

  // ---------------------------------------------------------------------------
  // Allocation grant: each requesting lane takes the entry at spec_head plus
  // the number of requesting lanes below it, so sparse requests stay packed.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PTR_W-1:0] rank;
    logic [PTR_W-1:0] rd_ptr;
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves it holding its old value and no latch is inferred.
    rank         = '0;
    rd_ptr       = '0;
    alloc_preg_o = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      rd_ptr = ptr_add(spec_head_q, rank);
      if (alloc_valid_i[k]) begin
        alloc_preg_o[k*PREG_W +: PREG_W] = entry_q[rd_ptr[IDX_W-1:0]];
      end
      rank = rank + PTR_W'(alloc_valid_i[k]);
    end
    alloc_n = rank;
  end

  // Readiness uses only the registered count: a preg freed this cycle is not
  // yet visible to rename. A flush blocks allocation outright.
  assign alloc_ready_o = !flush_i && (count_q >= alloc_n);
  assign fire          = alloc_ready_o && (alloc_n != '0);

  // ---------------------------------------------------------------------------
  // Commit and free bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_n = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      commit_n = commit_n + PTR_W'(commit_valid_i[k]);
    end
  end

  // Released pregs are compacted in lane order into tail, tail+1, ...
  always_comb begin
    logic [PTR_W-1:0] wr_ptr;
    free_n = '0;
    wr_ptr = '0;
    for (int j = 0; j < FREE_PORTS; j++) begin
      wr_ptr    = ptr_add(tail_q, free_n);
      wr_idx[j] = wr_ptr[IDX_W-1:0];
      free_n    = free_n + PTR_W'(free_valid_i[j]);
    end
  end

  // Commit is applied before the flush restore so the flush lands on the
  // post-commit architectural head.
  always_comb begin
    arch_head_d = ptr_add(arch_head_q, commit_n);
    tail_d      = ptr_add(tail_q, free_n);
    if (flush_i) begin
      spec_head_d = arch_head_d;
    end else if (fire) begin
      spec_head_d = ptr_add(spec_head_q, alloc_n);
    end else begin
      spec_head_d = spec_head_q;
    end
    count_d = ptr_dist(spec_head_d, tail_d);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    if (!a_rst_n) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= {1'b1, {IDX_W{1'b0}}};
      count_q     <= DEPTH_P;
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // NOTE: this storage is reset on purpose: its reset contents (the pregs not
  // mapped to architectural registers) are the initial free list itself.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= PREG_W'(ARCH_REG_NUM + i);
      end
    end else begin
      for (int j = 0; j < FREE_PORTS; j++) begin
        if (free_valid_i[j]) begin
          entry_q[wr_idx[j]] <= free_preg_i[j*PREG_W +: PREG_W];
        end
      end
    end
  end

  assign free_count_o = count_q;

  // ---------------------------------------------------------------------------
  // Illegal conditions: no recovery, only flagged.
  // ---------------------------------------------------------------------------
  logic count_ok;
  logic order_ok;

  assign count_ok = (count_d <= DEPTH_P);
  assign order_ok = (ptr_dist(arch_head_d, spec_head_q) <= DEPTH_P);

  a_count_in_range : assert property (@(posedge clk) disable iff (!a_rst_n) count_ok);
  a_arch_not_past_spec : assert property (@(posedge clk) disable iff (!a_rst_n) order_ok);

endmodule
